// File: rtl/aes_stream_pkg.sv
// Shared types and sizing helpers for the AES stream blocks.
// Used by stream_in_hs and stream_out_slot.
package aes_stream_pkg;

  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_KEY  = 1'b1;

  localparam int DIN_W_DEF  = 16;
  localparam int DOUT_W_DEF = 128;

  // Beats per block; returns 0 when the widths do not divide evenly.
  function automatic int beat_count(input int din_w, input int dout_w);
    if (din_w <= 0) return 0;
    if ((dout_w % din_w) != 0) return 0;
    return dout_w / din_w;
  endfunction

endpackage

// File: rtl/stream_out_slot.sv
// One-entry valid/ready holding register for a typed data block.
// A load and a drain may coincide; the slot then reloads and stays valid.
module stream_out_slot
  import aes_stream_pkg::*;
#(
  parameter int W = DOUT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] ld_data,
  input  logic         ld_type,
  input  logic         rout,
  output logic         vout,
  output logic [W-1:0] dout,
  output logic         tout
);

  logic         vout_q, vout_d;
  logic [W-1:0] data_q, data_d;
  logic         type_q, type_d;

  // Next slot contents: a load wins, otherwise a drain empties the slot.
  always_comb begin
    vout_d = vout_q;
    data_d = data_q;
    type_d = type_q;
    if (load) begin
      vout_d = 1'b1;
      data_d = ld_data;
      type_d = ld_type;
    end else if (vout_q && rout) begin
      vout_d = 1'b0;
    end
  end

  // Slot registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vout_q <= 1'b0;
      data_q <= '0;
      type_q <= TYPE_DATA;
    end else begin
      vout_q <= vout_d;
      data_q <= data_d;
      type_q <= type_d;
    end
  end

  assign vout = vout_q;
  assign dout = data_q;
  assign tout = type_q;

endmodule

// File: rtl/stream_in_hs.sv
// Packs DIN_W-bit beats into DOUT_W-bit typed blocks with valid/ready on both sides.
// Define STREAM_IN_HS_LE_EN for little-endian beat placement (default big-endian).
module stream_in_hs
  import aes_stream_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vin,
  output logic              rin,
  input  logic              tin,
  input  logic [DIN_W-1:0]  din,
  input  logic              abort,
  output logic              vout,
  input  logic              rout,
  output logic              tout,
  output logic [DOUT_W-1:0] dout,
  output logic              terr
);

  localparam int BEATS = beat_count(DIN_W, DOUT_W);
  localparam int CNT_W = (BEATS < 2) ? 1 : $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if (((DOUT_W % DIN_W) != 0) || (BEATS < 2)) begin : g_cfg_err
    $error("stream_in_hs: DOUT_W must be a multiple of DIN_W with >= 2 beats");
  end

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DOUT_W-1:0] asm_q, asm_d;
  logic              type_q, type_d;
  logic              terr_q, terr_d;
  logic [DOUT_W-1:0] asm_nx;
  logic              last, acc, load;

  assign last = (cnt_q == LAST);
  // rout reaches rin combinationally: only the final beat waits on the slot.
  assign rin  = rst_n & ~(last & vout & ~rout);
  assign acc  = vin & rin & ~abort;
  assign load = acc & last;

`ifdef STREAM_IN_HS_LE_EN
  assign asm_nx = {din, asm_q[DOUT_W-1:DIN_W]};
`else
  assign asm_nx = {asm_q[DOUT_W-DIN_W-1:0], din};
`endif

  // Beat counter, assembly shift, type latch and type-mismatch flag.
  always_comb begin
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    type_d = type_q;
    terr_d = 1'b0;
    if (abort) begin
      cnt_d = '0;
    end else if (acc) begin
      asm_d = asm_nx;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (cnt_q == '0) type_d = tin;
      else terr_d = (tin != type_q);
    end
  end

  // Assembly state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      asm_q  <= '0;
      type_q <= TYPE_DATA;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      type_q <= type_d;
      terr_q <= terr_d;
    end
  end

  assign terr = terr_q;

  stream_out_slot #(.W(DOUT_W)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .ld_data (asm_nx),
    .ld_type (type_q),
    .rout    (rout),
    .vout    (vout),
    .dout    (dout),
    .tout    (tout)
  );

endmodule

// File: tb/tb_stream_in_hs.sv
// Scoreboard bench for stream_in_hs (16->128 and 32->96 instances).
// Expected blocks follow the STREAM_IN_HS_LE_EN build setting.
module tb_stream_in_hs;

  typedef struct {
    logic [127:0] data;
    logic         typ;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vin = 1'b0, tin = 1'b0, abort = 1'b0, rout = 1'b0;
  logic [15:0]  din = '0;
  logic         rin, vout, tout, terr;
  logic [127:0] dout;

  logic         vin2 = 1'b0, rout2 = 1'b1;
  logic [31:0]  din2 = '0;
  logic         rin2, vout2, tout2, terr2;
  logic [95:0]  dout2;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_in_hs u_dut (
    .clk(clk), .rst_n(rst_n), .vin(vin), .rin(rin), .tin(tin),
    .din(din), .abort(abort), .vout(vout), .rout(rout),
    .tout(tout), .dout(dout), .terr(terr)
  );

  stream_in_hs #(.DIN_W(32), .DOUT_W(96)) u_dut96 (
    .clk(clk), .rst_n(rst_n), .vin(vin2), .rin(rin2), .tin(1'b0),
    .din(din2), .abort(1'b0), .vout(vout2), .rout(rout2),
    .tout(tout2), .dout(dout2), .terr(terr2)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every output transfer pops and checks one expected block.
  always @(negedge clk) begin
    if (rst_n && vout && rout) begin
      if (q.size() == 0) begin
        chk("unexpected_vout", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_dout"}, dout, e.data);
        chk({e.name, "_tout"}, {127'd0, tout}, {127'd0, e.typ});
      end
    end
  end

  function automatic logic [127:0] pk(input logic [15:0] b[8]);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef STREAM_IN_HS_LE_EN
      r[i*16 +: 16] = b[i];
`else
      r[(7-i)*16 +: 16] = b[i];
`endif
    end
    return r;
  endfunction

  task automatic push(input logic [15:0] b[8], input logic t,
                      input string nm);
    exp_t e;
    e.data = pk(b);
    e.typ  = t;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic beat(input logic [15:0] d, input logic t);
    int n;
    n = 0;
    vin = 1'b1; din = d; tin = t;
    @(negedge clk);
    while (!rin && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rin) chk("beat_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  task automatic send(input logic [15:0] b[8], input logic t);
    for (int i = 0; i < 8; i++) beat(b[i], t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b1[8], ba5[8], bb2[8], bf[8], bt[8], br[8];
    logic [127:0] exp_t1;
    logic [95:0]  exp96;
    int n;
    for (int i = 0; i < 8; i++) begin
      b1[i]  = 16'(i + 1);
      ba5[i] = 16'hA5A5;
      bb2[i] = 16'(16'h0100 + i);
      bf[i]  = 16'(16'h1111 * (i + 1));
      bt[i]  = 16'(16'h4000 + i);
      br[i]  = 16'(16'h5000 + i);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rin_low", {127'd0, rin}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_vout", {127'd0, vout}, 128'd0);
    chk("rst_dout", dout, 128'd0);
    chk("rst_tout", {127'd0, tout}, 128'd0);
    chk("rst_terr", {127'd0, terr}, 128'd0);
    chk("rst_rin", {127'd0, rin}, 128'd1);

    // Basic data block, hand-written constant
`ifdef STREAM_IN_HS_LE_EN
    exp_t1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
`else
    exp_t1 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
`endif
    rout = 1'b1;
    begin
      exp_t e;
      e.data = exp_t1; e.typ = 1'b0; e.name = "basic";
      q.push_back(e);
    end
    send(b1, 1'b0);
    chk("basic_vout_hi", {127'd0, vout}, 128'd1);
    @(posedge clk); #1;
    chk("basic_vout_one_cycle", {127'd0, vout}, 128'd0);

    // Key block held under backpressure, second block queued behind it
    rout = 1'b0;
    push(ba5, 1'b1, "key_held");
    push(bb2, 1'b0, "blk2");
    send(ba5, 1'b1);
    for (int i = 0; i < 7; i++) begin
      vin = 1'b1; din = bb2[i]; tin = 1'b0;
      @(negedge clk);
      chk("bp_rin_hi", {127'd0, rin}, 128'd1);
      @(posedge clk); #1;
    end
    din = bb2[7];
    @(negedge clk);
    chk("bp_rin_lo", {127'd0, rin}, 128'd0);
    chk("bp_vout", {127'd0, vout}, 128'd1);
    chk("bp_dout", dout, {8{16'hA5A5}});
    chk("bp_tout", {127'd0, tout}, 128'd1);
    @(posedge clk); #1;
    rout = 1'b1;
    @(negedge clk);
    chk("bp_rin_release", {127'd0, rin}, 128'd1);
    @(posedge clk); #1;
    vin = 1'b0; rout = 1'b0;
    chk("bp_reload_vout", {127'd0, vout}, 128'd1);
    rout = 1'b1;
    @(posedge clk); #1;
    chk("bp_drained", {127'd0, vout}, 128'd0);

    // Abort mid-block: only the fresh block may appear
    push(bf, 1'b0, "abort");
    for (int i = 0; i < 3; i++) beat(16'(16'h0F00 + i), 1'b0);
    vin = 1'b1; abort = 1'b1; din = 16'hDEAD;
    @(posedge clk); #1;
    vin = 1'b0; abort = 1'b0;
    send(bf, 1'b0);
    @(posedge clk); #1;

    // Type error on beat 4
    push(bt, 1'b0, "terr_blk");
    for (int i = 0; i < 3; i++) beat(bt[i], 1'b0);
    chk("terr_pre", {127'd0, terr}, 128'd0);
    beat(bt[3], 1'b1);
    chk("terr_pulse", {127'd0, terr}, 128'd1);
    for (int i = 4; i < 8; i++) begin
      beat(bt[i], 1'b0);
      if (i == 4) chk("terr_clear", {127'd0, terr}, 128'd0);
    end
    @(posedge clk); #1;

    // Reset with a full slot and a partial block
    rout = 1'b0;
    send(b1, 1'b1);
    for (int i = 0; i < 5; i++) beat(bf[i], 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_vout", {127'd0, vout}, 128'd0);
    chk("mid_rst_dout", dout, 128'd0);
    chk("mid_rst_tout", {127'd0, tout}, 128'd0);
    rout = 1'b1;
    push(br, 1'b0, "post_rst");
    send(br, 1'b0);
    @(posedge clk); #1;

    // 32 -> 96 instance
`ifdef STREAM_IN_HS_LE_EN
    exp96 = 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA;
`else
    exp96 = 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC;
`endif
    vin2 = 1'b1; din2 = 32'hAAAAAAAA;
    @(posedge clk); #1;
    din2 = 32'hBBBBBBBB;
    @(posedge clk); #1;
    din2 = 32'hCCCCCCCC;
    @(posedge clk); #1;
    vin2 = 1'b0;
    n = 0;
    while (!vout2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w96_vout", {127'd0, vout2}, 128'd1);
    chk("w96_dout", {32'd0, dout2}, {32'd0, exp96});

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
